// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder: FSM states, I/O page offsets and the
// default I/O page base address.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } busState_e;

  // Byte offsets within the 4 KB I/O page.
  localparam logic [11:0] IoPortOutOffset = 12'h000;
  localparam logic [11:0] IoPortInOffset  = 12'h004;
  localparam logic [11:0] IoCounterOffset = 12'h008;

  localparam logic [31:0] DefaultIoBase = 32'h1001_0000;

endpackage

// File: rtl/data_bus_responder_if.sv
// Pipeline MEM-stage bus between the core (master) and the data-bus responder (slave).
interface data_bus_responder_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Ready;

  modport master (
    output MemRead,
    output MemWrite,
    output Address,
    output WriteData,
    input  ReadData,
    input  Stall,
    input  Ready
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Address,
    input  WriteData,
    output ReadData,
    output Stall,
    output Ready
  );

endinterface

// File: rtl/data_bus_responder_ram.sv
// Word-addressed data RAM: synchronous write, combinational read of the same index.
// Contents are deliberately not touched by reset.
module data_ram_array #(
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned IndexWidth   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  writeEnable,
  input  logic [IndexWidth-1:0] index,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData
);

  logic [31:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (writeEnable) begin
      mem[index] <= writeData;
    end
  end

  assign readData = mem[index];

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: services MEM-stage loads/stores from a wait-stated RAM or a small
// I/O page (output port, synchronized input port, transaction counter).
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH        = 1024,
  parameter int unsigned WAIT_STATES         = 2,
  parameter logic [31:0] IO_BASE             = DefaultIoBase,
  // Value the transaction counter takes on reset; nonzero only to exercise wrap-around.
  parameter logic [31:0] COUNTER_RESET_VALUE = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  input  logic [7:0]           PortIn,
  output logic [31:0]          PortOut
);

  localparam int unsigned IndexWidth = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  busState_e stateQ, stateD;
  logic [3:0]  waitCntQ, waitCntD;
  logic [29:0] reqAddrQ, reqAddrD;  // word address, Address[31:2]
  logic [31:0] reqDataQ, reqDataD;
  logic        reqWriteQ, reqWriteD;
  logic        reqIoQ, reqIoD;

  logic [31:0] readDataQ;
  logic [31:0] portOutQ;
  logic [31:0] txnCountQ;
  logic [7:0]  syncQ1, syncQ2;

  logic        reqValid;
  logic        reqIsIo;
  logic        inResp;
  logic        stall;
  logic [11:0] ioOffset;
  logic [31:0] ioReadData;
  logic [31:0] ramReadData;
  logic [31:0] respData;
  logic        ramWriteEnable;
  logic [IndexWidth-1:0] ramIndex;
  logic        unusedAddrLsb;

  assign reqValid      = bus.MemRead | bus.MemWrite;
  assign reqIsIo       = (bus.Address[31:12] == IO_BASE[31:12]);
  assign unusedAddrLsb = ^bus.Address[1:0];

  always_comb begin
    stateD    = stateQ;
    waitCntD  = waitCntQ;
    reqAddrD  = reqAddrQ;
    reqDataD  = reqDataQ;
    reqWriteD = reqWriteQ;
    reqIoD    = reqIoQ;
    stall     = 1'b0;
    inResp    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (reqValid) begin
          stall     = 1'b1;
          reqAddrD  = bus.Address[31:2];
          reqDataD  = bus.WriteData;
          // A simultaneous read and write request is serviced as a write.
          reqWriteD = bus.MemWrite;
          reqIoD    = reqIsIo;
          waitCntD  = 4'(WAIT_STATES);
          stateD    = reqIsIo ? StResp : StAccess;
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (waitCntQ == 4'd0) begin
          stateD = StResp;
        end else begin
          waitCntD = waitCntQ - 4'd1;
        end
      end
      StResp: begin
        inResp = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  assign ioOffset = {reqAddrQ[9:0], 2'b00};

  always_comb begin
    ioReadData = 32'h0;
    if (ioOffset == IoPortOutOffset) begin
      ioReadData = portOutQ;
    end else if (ioOffset == IoPortInOffset) begin
      ioReadData = {24'h0, syncQ2};
    end else if (ioOffset == IoCounterOffset) begin
      ioReadData = txnCountQ;
    end
  end

  // Out-of-range word addresses wrap onto the RAM.
  assign ramIndex       = IndexWidth'(reqAddrQ % 30'(MEMORY_DEPTH));
  assign ramWriteEnable = inResp && reqWriteQ && !reqIoQ && !reset;
  assign respData       = reqIoQ ? ioReadData : ramReadData;

  data_ram_array #(
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .IndexWidth  (IndexWidth)
  ) u_ram (
    .clk        (clk),
    .writeEnable(ramWriteEnable),
    .index      (ramIndex),
    .writeData  (reqDataQ),
    .readData   (ramReadData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      waitCntQ  <= 4'd0;
      reqAddrQ  <= 30'h0;
      reqDataQ  <= 32'h0;
      reqWriteQ <= 1'b0;
      reqIoQ    <= 1'b0;
      readDataQ <= 32'h0;
      portOutQ  <= 32'h0;
      txnCountQ <= COUNTER_RESET_VALUE;
      syncQ1    <= 8'h0;
      syncQ2    <= 8'h0;
    end else begin
      stateQ    <= stateD;
      waitCntQ  <= waitCntD;
      reqAddrQ  <= reqAddrD;
      reqDataQ  <= reqDataD;
      reqWriteQ <= reqWriteD;
      reqIoQ    <= reqIoD;
      syncQ1    <= PortIn;
      syncQ2    <= syncQ1;
      if (inResp) begin
        txnCountQ <= txnCountQ + 32'd1;
        if (!reqWriteQ) begin
          readDataQ <= respData;
        end else if (reqIoQ && ioOffset == IoPortOutOffset) begin
          portOutQ <= reqDataQ;
        end
      end
    end
  end

  // Read data is presented during the Ready cycle and held afterwards; a reset landing
  // in RESP suppresses both Ready and the new data.
  assign bus.ReadData = (inResp && !reqWriteQ && !reset) ? respData : readDataQ;
  assign bus.Stall    = stall;
  assign bus.Ready    = inResp && !reset;
  assign PortOut      = portOutQ;

endmodule
